// File: rtl/ddr3_pll_lock_mon.sv
// DDR3 PLL lock supervisor: pulses the PLL reset, qualifies lock, releases the controller reset.
// Define LOCK_MON_LOSS_CNT_EN to build the saturating loss-of-lock counter; otherwise loss_cnt reads 0.
module ddr3_pll_lock_mon #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int MAX_A   = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The WAIT_LOCK cycle that first sees lock_s is the first qualified sample,
    // so STABLE only has to see LOCK_STABLE_CYC-1 further high cycles.
    localparam logic [TW-1:0] RST_LAST  = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] STAB_LAST = TW'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);

    if (RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 || LOCK_TIMEOUT_CYC < 2 ||
        MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_params
        $error("ddr3_pll_lock_mon: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lock_meta_q, lock_s_q;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic [7:0]    retry_cnt_q, retry_cnt_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock beats a coincident timeout.
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    timer_d = '0;
                    if (retry_cnt_q == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d     = ST_RESET_PLL;
                        retry_cnt_d = retry_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STAB_LAST) begin
                    state_d     = ST_LOCKED;
                    timer_d     = '0;
                    retry_cnt_d = 8'd0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!lock_s_q) begin
                    state_d = ST_RESET_PLL;
                    timer_d = '0;
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    state_d     = ST_RESET_PLL;
                    timer_d     = '0;
                    retry_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                timer_d = '0;
            end
        endcase

        // Outputs are registered copies of the next state, so they change on the transition edge.
        pll_rst_d   = (state_d == ST_RESET_PLL);
        sys_rst_n_d = (state_d == ST_LOCKED);
        ready_d     = (state_d == ST_LOCKED);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_RESET_PLL;
            timer_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_cnt_q <= 8'd0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;

`ifdef LOCK_MON_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt_q, loss_cnt_d;

    assign loss_evt = (state_q == ST_LOCKED) && !lock_s_q;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ddr3_pll_lock_mon.sv
// Directed bench for ddr3_pll_lock_mon with RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2.
module tb_ddr3_pll_lock_mon;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       retry_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int loss_events = 0;

    always #5 clk = ~clk;

    ddr3_pll_lock_mon #(
        .RST_PULSE_CYC   (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(32),
        .MAX_RETRY       (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .retry_req(retry_req),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_loss();
`ifdef LOCK_MON_LOSS_CNT_EN
        return (loss_events > 255) ? 8'd255 : 8'(loss_events);
`else
        return 8'd0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; pll_lock = 1'b0; retry_req = 1'b0;
        repeat (3) tick();
        total_cnt++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst); else pass_cnt++;
        total_cnt++; if (sys_rst_n !== 1'b0) $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (fail !== 1'b0) $display("FAIL reset_fail: got %b want 0", fail); else pass_cnt++;
        total_cnt++; if (retry_cnt !== 8'd0) $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); else pass_cnt++;
        total_cnt++; if (loss_cnt !== 8'd0) $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt); else pass_cnt++;
    endtask

    task automatic test_nominal();
        int n;
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_rst === 1'b1 && n < 50);
        total_cnt++; if (n != 4) $display("FAIL nominal_pulse_width: got %0d want 4", n); else pass_cnt++;
        repeat (10) tick();
        total_cnt++; if (sys_rst_n !== 1'b0) $display("FAIL nominal_pre_lock_sys_rst_n: got %b want 0", sys_rst_n); else pass_cnt++;
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
        total_cnt++; if (n != 10) $display("FAIL nominal_release_latency: got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL nominal_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (retry_cnt !== 8'd0) $display("FAIL nominal_retry_cnt: got %0d want 0", retry_cnt); else pass_cnt++;
        total_cnt++; if (pll_rst !== 1'b0) $display("FAIL nominal_pll_rst: got %b want 0", pll_rst); else pass_cnt++;
    endtask

    task automatic test_loss_of_lock();
        int n;
        pll_lock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (sys_rst_n !== 1'b0 && n < 20);
        loss_events++;
        total_cnt++; if (n != 3) $display("FAIL loss_latency: got %0d want 3", n); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL loss_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (pll_rst !== 1'b1) $display("FAIL loss_pll_rst: got %b want 1", pll_rst); else pass_cnt++;
        total_cnt++; if (loss_cnt !== exp_loss()) $display("FAIL loss_cnt_one: got %0d want %0d", loss_cnt, exp_loss()); else pass_cnt++;
        n = 0;
        do begin tick(); n++; end while (pll_rst === 1'b1 && n < 50);
        total_cnt++; if (n != 4) $display("FAIL loss_pulse_width: got %0d want 4", n); else pass_cnt++;
    endtask

    task automatic test_lock_glitch();
        pll_lock = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 5) pll_lock = 1'b0;
            if (i == 8) pll_lock = 1'b1;
            if (i == 10 || i == 17) begin
                total_cnt++;
                if (sys_rst_n !== 1'b0) $display("FAIL glitch_early_release: cycle %0d got %b want 0", i, sys_rst_n); else pass_cnt++;
            end
        end
        total_cnt++; if (sys_rst_n !== 1'b1) $display("FAIL glitch_release: got %b want 1", sys_rst_n); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL glitch_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (retry_cnt !== 8'd0) $display("FAIL glitch_retry_cnt: got %0d want 0", retry_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout_fail();
        int   n, hi_run, lo_run, pulses;
        logic prev, released, done;
        pll_lock = 1'b0;
        loss_events++;
        prev = pll_rst; hi_run = 0; lo_run = 0; pulses = 0; released = 1'b0; done = 1'b0; n = 0;
        while (!done && n < 400) begin
            tick(); n++;
            if (fail === 1'b1) begin
                done = 1'b1;
            end else if (pll_rst === 1'b1) begin
                if (prev !== 1'b1) begin
                    if (pulses > 0) begin
                        total_cnt++;
                        if (lo_run != 32) $display("FAIL timeout_gap: got %0d want 32", lo_run); else pass_cnt++;
                    end
                    pulses++;
                    total_cnt++;
                    if (retry_cnt !== 8'(pulses - 1)) $display("FAIL timeout_retry_cnt: got %0d want %0d", retry_cnt, pulses - 1); else pass_cnt++;
                    hi_run = 0;
                end
                hi_run++;
                prev = 1'b1;
            end else begin
                if (prev === 1'b1) begin
                    total_cnt++;
                    if (hi_run != 4) $display("FAIL timeout_pulse_width: got %0d want 4", hi_run); else pass_cnt++;
                    lo_run = 0;
                end
                lo_run++;
                if (pulses > 0 && sys_rst_n !== 1'b0) released = 1'b1;
                prev = 1'b0;
            end
        end
        total_cnt++; if (!done) $display("FAIL timeout_reach_fail: got fail=%b want 1 within 400 cycles", fail); else pass_cnt++;
        total_cnt++; if (pulses != 3) $display("FAIL timeout_pulse_count: got %0d want 3", pulses); else pass_cnt++;
        total_cnt++; if (lo_run != 32) $display("FAIL timeout_last_gap: got %0d want 32", lo_run); else pass_cnt++;
        total_cnt++; if (retry_cnt !== 8'd2) $display("FAIL fail_retry_cnt: got %0d want 2", retry_cnt); else pass_cnt++;
        total_cnt++; if (released !== 1'b0 || sys_rst_n !== 1'b0) $display("FAIL fail_sys_rst_n: got released=%b now=%b want 0", released, sys_rst_n); else pass_cnt++;
        total_cnt++; if (pll_rst !== 1'b0) $display("FAIL fail_pll_rst: got %b want 0", pll_rst); else pass_cnt++;
    endtask

    task automatic test_recovery();
        int n;
        pll_lock = 1'b1;
        repeat (4) tick();
        total_cnt++; if (fail !== 1'b1 || sys_rst_n !== 1'b0) $display("FAIL fail_sticky: got fail=%b sys_rst_n=%b want 1/0", fail, sys_rst_n); else pass_cnt++;
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        total_cnt++; if (fail !== 1'b0) $display("FAIL recover_fail: got %b want 0", fail); else pass_cnt++;
        total_cnt++; if (retry_cnt !== 8'd0) $display("FAIL recover_retry_cnt: got %0d want 0", retry_cnt); else pass_cnt++;
        total_cnt++; if (pll_rst !== 1'b1) $display("FAIL recover_pll_rst: got %b want 1", pll_rst); else pass_cnt++;
        n = 1;
        tick();
        while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
        total_cnt++; if (n != 4) $display("FAIL recover_pulse_width: got %0d want 4", n); else pass_cnt++;
        n = 0;
        do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
        total_cnt++; if (n != 8) $display("FAIL recover_release: got %0d want 8", n); else pass_cnt++;
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (sys_rst_n !== 1'b1 || ready !== 1'b1 || pll_rst !== 1'b0 || fail !== 1'b0)
            $display("FAIL locked_retry_ignored: got sys_rst_n=%b ready=%b pll_rst=%b fail=%b want 1/1/0/0", sys_rst_n, ready, pll_rst, fail);
        else pass_cnt++;
    endtask

    task automatic test_loss_saturation();
        int n;
        logic ok;
        ok = 1'b1;
        while (loss_events < 300 && ok) begin
            pll_lock = 1'b0;
            n = 0;
            do begin tick(); n++; end while (sys_rst_n !== 1'b0 && n < 20);
            if (sys_rst_n !== 1'b0) ok = 1'b0;
            loss_events++;
            pll_lock = 1'b1;
            n = 0;
            do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
            if (sys_rst_n !== 1'b1) ok = 1'b0;
            if (loss_events == 254 || loss_events == 255) begin
                total_cnt++;
                if (loss_cnt !== exp_loss()) $display("FAIL loss_cnt_ramp: event %0d got %0d want %0d", loss_events, loss_cnt, exp_loss()); else pass_cnt++;
            end
        end
        total_cnt++; if (!ok) $display("FAIL loss_loop_stalled: got stall at event %0d want 300 events", loss_events); else pass_cnt++;
        total_cnt++; if (loss_cnt !== exp_loss()) $display("FAIL loss_cnt_saturate: got %0d want %0d", loss_cnt, exp_loss()); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        pll_lock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b1 && n < 20);
        loss_events++;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || fail !== 1'b0 || retry_cnt !== 8'd0 || loss_cnt !== 8'd0)
            $display("FAIL async_reset_values: got pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d want 1/0/0/0/0/0",
                     pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt);
        else pass_cnt++;
        loss_events = 0;
        tick(); tick();
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_rst === 1'b1 && n < 50);
        total_cnt++; if (n != 4) $display("FAIL async_pulse_width: got %0d want 4", n); else pass_cnt++;
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (sys_rst_n !== 1'b1 && n < 100);
        total_cnt++; if (sys_rst_n !== 1'b1) $display("FAIL async_relock: got %b want 1", sys_rst_n); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || pll_rst !== 1'b1)
            $display("FAIL async_reset_locked: got sys_rst_n=%b ready=%b pll_rst=%b want 0/0/1", sys_rst_n, ready, pll_rst);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss_of_lock();
        test_lock_glitch();
        test_timeout_fail();
        test_recovery();
        test_loss_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
